// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a byte-addressed data memory.
// Each grant runs IDLE -> ACCESS -> RESP; alignment, range and size faults are flagged at grant time.
module dmem_port_arbiter #(
  parameter int AWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int MEM_BYTES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_rw,
  input  logic [AWIDTH-1:0] p0_addr,
  input  logic [DWIDTH-1:0] p0_wdata,
  input  logic [2:0]        p0_size,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DWIDTH-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_rw,
  input  logic [AWIDTH-1:0] p1_addr,
  input  logic [DWIDTH-1:0] p1_wdata,
  input  logic [2:0]        p1_size,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DWIDTH-1:0] p1_rdata,
  output logic              mem_rw,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_dataW,
  output logic [2:0]        mem_size,
  input  logic [DWIDTH-1:0] mem_dataR,
  output logic              busy,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a requester raises req with stable fields and holds it until its ack;
  // ack is a one-cycle pulse with err/rdata valid alongside, rdata held until that port's next ack.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [AWIDTH:0] LP_LIMIT = (AWIDTH+1)'(MEM_BYTES);

  state_t              r_state;
  state_t              w_next;
  logic                w_grant;
  logic                w_winner;
  logic                w_sel_rw;
  logic [AWIDTH-1:0]   w_sel_addr;
  logic [DWIDTH-1:0]   w_sel_wdata;
  logic [2:0]          w_sel_size;
  logic [AWIDTH:0]     w_nbytes;
  logic [AWIDTH:0]     w_end;
  logic                w_err;

  logic                r_last_grant;
  logic                r_grant;
  logic                r_rw;
  logic                r_err;
  logic [AWIDTH-1:0]   r_mem_addr;
  logic [DWIDTH-1:0]   r_mem_dataW;
  logic [2:0]          r_mem_size;
  logic                r_p0_ack;
  logic                r_p0_err;
  logic [DWIDTH-1:0]   r_p0_rdata;
  logic                r_p1_ack;
  logic                r_p1_err;
  logic [DWIDTH-1:0]   r_p1_rdata;

  // On a tie the port that did not win last time goes first.
  assign w_winner    = (p0_req & p1_req) ? ~r_last_grant : p1_req;
  assign w_sel_rw    = w_winner ? p1_rw    : p0_rw;
  assign w_sel_addr  = w_winner ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_winner ? p1_wdata : p0_wdata;
  assign w_sel_size  = w_winner ? p1_size  : p0_size;

  always_comb begin
    w_nbytes = (AWIDTH+1)'(1);
    if (w_sel_size[1:0] == 2'b00)      w_nbytes = (AWIDTH+1)'(4);
    else if (w_sel_size[1:0] == 2'b01) w_nbytes = (AWIDTH+1)'(2);
    // One extra bit so addr + nbytes cannot wrap past the limit.
    w_end = {1'b0, w_sel_addr} + w_nbytes;
    w_err = (w_sel_size == 3'b111)
          | ((w_sel_size[1:0] == 2'b00) & (w_sel_addr[1:0] != 2'b00))
          | ((w_sel_size[1:0] == 2'b01) & w_sel_addr[0])
          | (w_end > LP_LIMIT);
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (p0_req | p1_req) begin
          w_grant = 1'b1;
          w_next  = ST_ACCESS;
        end
      end
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_rw         <= 1'b0;
      r_err        <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_dataW  <= '0;
      r_mem_size   <= '0;
      r_p0_ack     <= 1'b0;
      r_p0_err     <= 1'b0;
      r_p0_rdata   <= '0;
      r_p1_ack     <= 1'b0;
      r_p1_err     <= 1'b0;
      r_p1_rdata   <= '0;
    end else begin
      if (w_grant) begin
        r_last_grant <= w_winner;
        r_grant      <= w_winner;
        r_rw         <= w_sel_rw;
        r_err        <= w_err;
        r_mem_addr   <= w_sel_addr;
        r_mem_dataW  <= w_sel_wdata;
        r_mem_size   <= w_sel_size;
      end
      if (r_state == ST_ACCESS) begin
        if (r_grant) begin
          r_p1_ack   <= 1'b1;
          r_p1_err   <= r_err;
          r_p1_rdata <= (r_rw | r_err) ? '0 : mem_dataR;
        end else begin
          r_p0_ack   <= 1'b1;
          r_p0_err   <= r_err;
          r_p0_rdata <= (r_rw | r_err) ? '0 : mem_dataR;
        end
      end
      if (r_state == ST_RESP) begin
        r_p0_ack <= 1'b0;
        r_p0_err <= 1'b0;
        r_p1_ack <= 1'b0;
        r_p1_err <= 1'b0;
      end
    end
  end

  // Write strobe is decoded from state so an async reset kills it immediately.
  assign mem_rw      = (r_state == ST_ACCESS) & r_rw & ~r_err;
  assign mem_addr    = r_mem_addr;
  assign mem_dataW   = r_mem_dataW;
  assign mem_size    = r_mem_size;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;
  assign p0_ack      = r_p0_ack;
  assign p0_err      = r_p0_err;
  assign p0_rdata    = r_p0_rdata;
  assign p1_ack      = r_p1_ack;
  assign p1_err      = r_p1_err;
  assign p1_rdata    = r_p1_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: byte memory attached to the memory port, byte-array reference model.
module tb_dmem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_rw, p1_req, p1_rw;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic [2:0]    p0_size, p1_size;
  logic          p0_ack, p0_err, p1_ack, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dataW, mem_dataR;
  logic [2:0]    mem_size;
  logic          busy;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  bit model_last = 1'b1;
  logic [DW-1:0] exp_q[$];

  logic [7:0] dut_mem [0:MB-1];
  logic [7:0] ref_mem [0:MB-1];
  logic [7:0] rd_b0, rd_b1, rd_b2, rd_b3;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MEM_BYTES(MB)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_size(p0_size),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_size(p1_size),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_dataW(mem_dataW), .mem_size(mem_size),
    .mem_dataR(mem_dataR), .busy(busy), .o_dbg_state(dbg_state)
  );

  // Data memory: little-endian, asynchronous read with size extension, synchronous write.
  always_comb begin
    rd_b0 = dut_mem[mem_addr[7:0]];
    rd_b1 = dut_mem[8'(mem_addr[7:0] + 8'd1)];
    rd_b2 = dut_mem[8'(mem_addr[7:0] + 8'd2)];
    rd_b3 = dut_mem[8'(mem_addr[7:0] + 8'd3)];
    case (mem_size)
      3'b001:  mem_dataR = {16'h0000, rd_b1, rd_b0};
      3'b101:  mem_dataR = {{16{rd_b1[7]}}, rd_b1, rd_b0};
      3'b010:  mem_dataR = {24'h000000, rd_b0};
      3'b110:  mem_dataR = {{24{rd_b0[7]}}, rd_b0};
      default: mem_dataR = {rd_b3, rd_b2, rd_b1, rd_b0};
    endcase
  end

  always @(posedge clk) begin
    if (mem_rw) begin
      dut_mem[mem_addr[7:0]] <= mem_dataW[7:0];
      if (mem_size[1:0] != 2'b10) dut_mem[8'(mem_addr[7:0] + 8'd1)] <= mem_dataW[15:8];
      if (mem_size[1:0] == 2'b00) begin
        dut_mem[8'(mem_addr[7:0] + 8'd2)] <= mem_dataW[23:16];
        dut_mem[8'(mem_addr[7:0] + 8'd3)] <= mem_dataW[31:24];
      end
    end
  end

  // Reference model
  function automatic int nbytes(input logic [2:0] size);
    if (size[1:0] == 2'b00) return 4;
    if (size[1:0] == 2'b01) return 2;
    return 1;
  endfunction

  function automatic logic model_err(input logic [31:0] addr, input logic [2:0] size);
    int nb;
    nb = nbytes(size);
    if (size == 3'b111) return 1'b1;
    if (nb == 4 && (addr % 4) != 0) return 1'b1;
    if (nb == 2 && (addr % 2) != 0) return 1'b1;
    if (longint'(addr) + longint'(nb) > longint'(MB)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] size);
    longint v;
    int nb;
    nb = nbytes(size);
    v = 0;
    for (int i = 0; i < nb; i++) v += longint'(ref_mem[addr + i]) << (8 * i);
    if (size[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  function automatic void ref_store(input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [2:0] size);
    for (int i = 0; i < nbytes(size); i++) ref_mem[addr + i] = wdata[8*i +: 8];
  endfunction

  // Driver
  task automatic drive(input int port, input logic req, input logic rw, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] size);
    if (port == 0) begin
      p0_req = req; p0_rw = rw; p0_addr = addr; p0_wdata = wdata; p0_size = size;
    end else begin
      p1_req = req; p1_rw = rw; p1_addr = addr; p1_wdata = wdata; p1_size = size;
    end
  endtask

  // One isolated transaction on one port, checked cycle by cycle.
  task automatic do_txn(input int port, input logic rw, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size, input string name);
    logic        exp_err;
    logic [31:0] exp_rd, exp_front, other_before;
    logic        own_ack, oth_ack;
    bit          seen;
    exp_err = model_err(addr, size);
    if (rw) begin
      exp_rd = '0;
      if (!exp_err) ref_store(addr, wdata, size);
    end else begin
      exp_rd = exp_err ? 32'h0 : ref_load(addr, size);
    end
    exp_q.push_back(exp_rd);
    model_last = port[0];
    other_before = (port == 0) ? p1_rdata : p0_rdata;
    @(negedge clk);
    drive(port, 1'b1, rw, addr, wdata, size);
    seen = 1'b0;
    for (int n = 1; n <= 6 && !seen; n++) begin
      @(negedge clk);
      own_ack = (port == 0) ? p0_ack : p1_ack;
      oth_ack = (port == 0) ? p1_ack : p0_ack;
      if (n == 1) begin
        n_checks++;
        if (mem_rw !== (rw & ~exp_err)) begin
          n_errors++; $display("FAIL %s mem_rw_access: got %b want %b", name, mem_rw, rw & ~exp_err);
        end
        n_checks++;
        if (busy !== 1'b1) begin
          n_errors++; $display("FAIL %s busy_access: got %b want 1", name, busy);
        end
      end
      n_checks++;
      if (oth_ack !== 1'b0) begin
        n_errors++; $display("FAIL %s other_ack: got %b want 0 at cycle %0d", name, oth_ack, n);
      end
      if (own_ack === 1'b1) begin
        seen = 1'b1;
        exp_front = exp_q.pop_front();
        n_checks++;
        if (n != 2) begin
          n_errors++; $display("FAIL %s ack_latency: got %0d want 2", name, n);
        end
        n_checks++;
        if (((port == 0) ? p0_err : p1_err) !== exp_err) begin
          n_errors++; $display("FAIL %s err: got %b want %b", name, (port == 0) ? p0_err : p1_err, exp_err);
        end
        n_checks++;
        if (((port == 0) ? p0_rdata : p1_rdata) !== exp_front) begin
          n_errors++; $display("FAIL %s rdata: got %h want %h", name, (port == 0) ? p0_rdata : p1_rdata, exp_front);
        end
        n_checks++;
        if (mem_rw !== 1'b0) begin
          n_errors++; $display("FAIL %s mem_rw_resp: got %b want 0", name, mem_rw);
        end
        drive(port, 1'b0, rw, addr, wdata, size);
      end
    end
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL %s ack_timeout: got no ack want ack within 6 cycles", name);
      void'(exp_q.pop_front());
      drive(port, 1'b0, rw, addr, wdata, size);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || p0_ack !== 1'b0 || p1_ack !== 1'b0) begin
      n_errors++; $display("FAIL %s idle_after: got busy=%b acks=%b%b want 0 00", name, busy, p0_ack, p1_ack);
    end
    n_checks++;
    if (((port == 0) ? p0_rdata : p1_rdata) !== exp_rd) begin
      n_errors++; $display("FAIL %s rdata_hold: got %h want %h", name, (port == 0) ? p0_rdata : p1_rdata, exp_rd);
    end
    n_checks++;
    if (((port == 0) ? p1_rdata : p0_rdata) !== other_before) begin
      n_errors++; $display("FAIL %s other_rdata: got %h want %h", name, (port == 0) ? p1_rdata : p0_rdata, other_before);
    end
  endtask

  // Requests held continuously (loads); each grant decided by round-robin rule.
  task automatic test_held(input bit r0, input bit r1, input int ntx, input string name);
    logic [31:0] a0, a1, exp_rd;
    bit w;
    a0 = 32'($urandom_range(0, 63) * 4);
    a1 = 32'($urandom_range(0, 63) * 4);
    w = 1'b0;
    @(negedge clk);
    drive(0, r0, 1'b0, a0, 32'h0, 3'b000);
    drive(1, r1, 1'b0, a1, 32'h0, 3'b000);
    for (int n = 1; n <= 3 * ntx - 1; n++) begin
      if (n % 3 == 1) begin
        w = (r0 && r1) ? ~model_last : r1;
        model_last = w;
      end
      @(negedge clk);
      n_checks++;
      if (busy !== (n % 3 != 0)) begin
        n_errors++; $display("FAIL %s busy: got %b want %b at cycle %0d", name, busy, n % 3 != 0, n);
      end
      n_checks++;
      if (mem_rw !== 1'b0) begin
        n_errors++; $display("FAIL %s mem_rw: got %b want 0 at cycle %0d", name, mem_rw, n);
      end
      n_checks++;
      if (n % 3 == 2) begin
        if (p0_ack !== (w == 1'b0) || p1_ack !== (w == 1'b1)) begin
          n_errors++; $display("FAIL %s grant: got acks p0=%b p1=%b want port %0d at cycle %0d", name, p0_ack, p1_ack, w, n);
        end
        exp_rd = ref_load(w ? a1 : a0, 3'b000);
        n_checks++;
        if ((w ? p1_rdata : p0_rdata) !== exp_rd) begin
          n_errors++; $display("FAIL %s rdata: got %h want %h", name, w ? p1_rdata : p0_rdata, exp_rd);
        end
      end else if (p0_ack !== 1'b0 || p1_ack !== 1'b0) begin
        n_errors++; $display("FAIL %s stray_ack: got p0=%b p1=%b want 0 0 at cycle %0d", name, p0_ack, p1_ack, n);
      end
      if (n == 3 * ntx - 1) begin
        p0_req = 1'b0;
        p1_req = 1'b0;
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL %s final_idle: got busy=%b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({p0_ack, p0_err, p1_ack, p1_err, mem_rw, busy} !== 6'b0 || p0_rdata !== '0 || p1_rdata !== '0) begin
      n_errors++; $display("FAIL reset_flags: got %b rd0=%h rd1=%h want all 0", {p0_ack, p0_err, p1_ack, p1_err, mem_rw, busy}, p0_rdata, p1_rdata);
    end
    n_checks++;
    if (mem_addr !== '0 || mem_dataW !== '0 || mem_size !== 3'b000) begin
      n_errors++; $display("FAIL reset_mem_regs: got %h %h %b want 0", mem_addr, mem_dataW, mem_size);
    end
    rst = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_store_load();
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b000, "p0_store_w");
    do_txn(0, 1'b0, 32'h10, 32'h0, 3'b000, "p0_load_w");
    do_txn(1, 1'b0, 32'h12, 32'h0, 3'b001, "p1_load_h");
  endtask

  task automatic test_errors();
    do_txn(1, 1'b0, 32'h11, 32'h0, 3'b001, "err_misaligned_h");
    do_txn(1, 1'b0, 32'hFD, 32'h0, 3'b000, "err_range_w");
    do_txn(1, 1'b0, 32'h20, 32'h0, 3'b111, "err_size_d");
    do_txn(1, 1'b1, 32'h100, 32'h11223344, 3'b010, "err_store_range");
    do_txn(0, 1'b1, 32'h22, 32'h55667788, 3'b000, "err_store_misaligned");
  endtask

  task automatic test_boundary();
    do_txn(0, 1'b1, 32'h20, 32'h00000080, 3'b010, "store_b");
    do_txn(0, 1'b0, 32'h20, 32'h0, 3'b110, "load_b_signed");
    do_txn(0, 1'b1, 32'hFC, 32'hA5C3E187, 3'b000, "store_w_edge");
    do_txn(1, 1'b0, 32'hFC, 32'h0, 3'b100, "load_w_edge");
    do_txn(1, 1'b0, 32'hFE, 32'h0, 3'b101, "load_h_signed_edge");
    do_txn(0, 1'b0, 32'hFF, 32'h0, 3'b010, "load_b_last");
  endtask

  task automatic test_reset_abort();
    do_txn(0, 1'b1, 32'h40, 32'hCAFEF00D, 3'b000, "prior_store");
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h40, 32'h12345678, 3'b000);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (mem_rw !== 1'b0 || busy !== 1'b0 || p0_ack !== 1'b0) begin
      n_errors++; $display("FAIL abort_immediate: got mem_rw=%b busy=%b ack=%b want 0 0 0", mem_rw, busy, p0_ack);
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    rst = 1'b0;
    model_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (p0_ack !== 1'b0 || busy !== 1'b0) begin
        n_errors++; $display("FAIL abort_no_ack: got ack=%b busy=%b want 0 0", p0_ack, busy);
      end
    end
    do_txn(0, 1'b0, 32'h40, 32'h0, 3'b000, "load_after_abort");
  endtask

  task automatic test_random(input int count);
    logic [2:0] sizes [0:6];
    logic [31:0] addr;
    sizes[0] = 3'b000; sizes[1] = 3'b001; sizes[2] = 3'b010; sizes[3] = 3'b100;
    sizes[4] = 3'b101; sizes[5] = 3'b110; sizes[6] = 3'b111;
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 3) == 0) addr = 32'($urandom_range(240, 270));
      else addr = 32'($urandom_range(0, 255));
      do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom,
             sizes[$urandom_range(0, 6)], "random");
    end
  endtask

  initial begin
    for (int i = 0; i < MB; i++) begin
      dut_mem[i] = 8'($urandom);
      ref_mem[i] = dut_mem[i];
    end
    test_reset();
    test_held(1'b1, 1'b1, 4, "arb_alternate");
    test_store_load();
    test_errors();
    test_boundary();
    test_reset_abort();
    test_held(1'b0, 1'b1, 3, "p1_back_to_back");
    test_held(1'b1, 1'b1, 3, "arb_again");
    test_random(40);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Two-requester arbiter and access sequencer in front of the byte-addressed data memory (synchronous write, asynchronous read, 3-bit size_type). Port 0 is the core load/store unit; port 1 is the debug/DMA loader. It grants one transaction at a time with round-robin fairness, registers the winner's fields onto the memory port, and checks alignment, range and size. It returns read data or an error through a one-cycle acknowledge.

Parameters:
AWIDTH, 32, address width of requester and memory ports
DWIDTH, 32, data width
MEM_BYTES, 256, memory depth in bytes; range-check limit

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
p0_req  in  1  port 0 request; held until p0_ack
p0_rw  in  1  port 0: 1=store, 0=load
p0_addr  in  AWIDTH  port 0 byte address
p0_wdata  in  DWIDTH  port 0 store data
p0_size  in  3  port 0 size_type (000 W, 001 H, 010 B, 100 W signed, 101 H signed, 110 B signed, 111 D)
p0_ack  out  1  port 0 one-cycle completion pulse
p0_err  out  1  port 0 error flag, valid with p0_ack
p0_rdata  out  DWIDTH  port 0 load data, valid with p0_ack
p1_req, p1_rw, p1_addr, p1_wdata, p1_size, p1_ack, p1_err, p1_rdata: same as port 0, for port 1
mem_rw  out  1  memory write enable
mem_addr  out  AWIDTH  memory address (registered)
mem_dataW  out  DWIDTH  memory write data (registered)
mem_size  out  3  memory size_type (registered)
mem_dataR  in  DWIDTH  memory asynchronous read data
busy  out  1  high in ACCESS and RESP

Behaviour:
- Reset (async, immediate): state=IDLE, last_grant=1 (port 0 wins first tie), all acks/errs 0, rdata 0, mem_rw 0, mem_addr/mem_dataW/mem_size 0, busy 0. A transaction in flight is aborted: no write, no ack.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. Each transaction takes 3 cycles, so sustained throughput is one per 3 cycles.
- IDLE:
  - No request: stay in IDLE.
  - Only one req high: grant that port.
  - Both high: grant the port != last_grant.
  - On grant: register the winner's addr/wdata/size/rw into the mem_* registers and grant id; set last_grant=winner; compute err_q; go to ACCESS.
- err_q=1 when any of the following holds:
  - size==111.
  - Misaligned: W or W-signed with addr[1:0]!=0; H or H-signed with addr[0]!=0.
  - Out of range: addr+nbytes > MEM_BYTES, where nbytes = 4/2/1 for W/H/B. Compute in AWIDTH+1 bits so the addition cannot wrap.
- ACCESS (1 cycle):
  - mem_rw = rw_q & ~err_q (combinational from registered state), so the store commits at the edge that ends ACCESS.
  - mem_rw is 0 in every other state.
  - At that edge: granted port's rdata <= (rw_q|err_q) ? 0 : mem_dataR; ack <= 1; err <= err_q. Go to RESP.
- RESP (1 cycle):
  - Granted port's ack=1 and err valid; rdata is held until that port's next ack.
  - Requests are not sampled. The requester drops or changes req by the end of RESP.
  - Go to IDLE; ack clears at the next edge.
- The non-granted port's ack, err and rdata stay unchanged and low/held throughout.
- Requests arriving in ACCESS/RESP wait. Req dropped before ack is a protocol violation: the transaction still completes.
- An erroring store never writes memory. An erroring load returns 0.

Test Plan:
- Port 0 store: W, 0x10, 0xDEADBEEF, then load W 0x10 -> p0_ack at cycle 3 of each transaction, p0_err=0, mem_rw high only in ACCESS, p0_rdata=0xDEADBEEF.
- Both req in the same IDLE cycle after reset -> port 0 granted first; with both held, grants alternate 0,1,0,1; each ack separated by 3 cycles.
- Port 1 load H at 0x11 (misaligned); load W at 0xFD (out of range, MEM_BYTES=256); size 111 -> p1_err=1, p1_rdata=0, mem_rw never high.
- Store B 0x80 to 0x20, then load B-signed 0x20 -> p0_rdata=0xFFFFFF80; store W at 0xFC -> err=0 (exact fit at boundary).
- Assert rst during ACCESS of a store W 0x40 = 0x12345678 -> mem_rw drops immediately, no ack; a later load W 0x40 returns the prior contents.
- Port 1 holds req continuously while port 0 idle -> back-to-back grants to port 1 every 3 cycles; busy low only in the IDLE cycles.
